// File: rtl/uart_link_pkg.sv
// Shared types and constants for the FPGA-to-Nano UART link scheduler.
package uart_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TYPE,
    ST_PAYLOAD,
    ST_CSUM,
    ST_GAP
  } state_e;

  typedef enum logic {
    GNT_IMAGE  = 1'b0,
    GNT_STATUS = 1'b1
  } grant_e;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] TYPE_IMAGE  = 8'h01;
  localparam logic [7:0] TYPE_STATUS = 8'h02;

  function automatic logic [7:0] type_byte(input grant_e g);
    return (g == GNT_STATUS) ? TYPE_STATUS : TYPE_IMAGE;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start accepted during the last stop-bit cycle chains
// the next byte with no idle time on the line.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          active_q;
  logic [3:0]    bit_q;     // 0 start, 1..8 data, 9 stop
  logic [CW-1:0] cnt_q;
  logic [7:0]    shf_q;
  logic          tx_q;
  logic          bit_end;

  assign bit_end = active_q && (cnt_q == CNT_LAST);
  assign done    = bit_end && (bit_q == 4'd9);
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      shf_q    <= 8'h00;
      tx_q     <= 1'b1;
    end else if (start && (!active_q || done)) begin
      active_q <= 1'b1;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      shf_q    <= data;
      tx_q     <= 1'b0;
    end else if (bit_end) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        active_q <= 1'b0;
        tx_q     <= 1'b1;
      end else begin
        bit_q <= bit_q + 4'd1;
        // entering bit_q+1: data bit bit_q, or the stop bit after data bit 7
        tx_q  <= (bit_q == 4'd8) ? 1'b1 : shf_q[bit_q[2:0]];
      end
    end else if (active_q) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_link_scheduler.sv
// Round-robin scheduler of image frames and status words onto one framed,
// checksummed 8N1 UART link.
module uart_link_scheduler
  import uart_link_pkg::*;
#(
  parameter int NUM_PIXELS   = 76800,
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_CYCLES   = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        img_req,
  output logic        img_done,
  output logic [16:0] address,
  input  logic [11:0] pixel,
  input  logic        status_valid,
  input  logic [31:0] status_word,
  output logic        status_ready,
  output logic        uart_out,
  output logic        busy
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [16:0]   LAST_PIX = 17'(NUM_PIXELS - 1);

  state_e        state_q, state_d;
  grant_e        gnt_q, gnt_d;
  grant_e        last_gnt_q, last_gnt_d;
  logic          stat_pend_q, stat_pend_d;
  logic [31:0]   stat_word_q, stat_word_d;
  logic [7:0]    csum_q, csum_d;
  logic [16:0]   addr_q, addr_d;
  logic          lo_q, lo_d;
  logic [1:0]    bidx_q, bidx_d;
  logic          last_pix_q, last_pix_d;
  logic [7:0]    pix_q, pix_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          img_done_q, img_done_d;

  logic       tx_start, tx_done;
  logic [7:0] tx_data;

  // Next payload byte: index/half selection for the byte about to start.
  logic       first_pl;
  logic [1:0] nxt_idx;
  logic       nxt_lo;
  logic [7:0] nxt_byte;
  logic       pl_last;

  assign first_pl = (state_q == ST_TYPE);
  assign nxt_idx  = first_pl ? 2'd0 : bidx_q + 2'd1;
  assign nxt_lo   = first_pl ? 1'b0 : !lo_q;
  assign nxt_byte = (gnt_q == GNT_STATUS) ? stat_word_q[{~nxt_idx, 3'b000} +: 8]
                  : (nxt_lo ? pix_q : {4'h0, pixel[11:8]});
  assign pl_last  = (gnt_q == GNT_STATUS) ? (bidx_q == 2'd3) : (lo_q && last_pix_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    stat_pend_d = stat_pend_q;
    stat_word_d = stat_word_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    lo_d        = lo_q;
    bidx_d      = bidx_q;
    last_pix_d  = last_pix_q;
    pix_d       = pix_q;
    gap_d       = gap_q;
    img_done_d  = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;

    if (status_valid && !stat_pend_q) begin
      stat_pend_d = 1'b1;
      stat_word_d = status_word;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (img_req || stat_pend_q) begin
          if (img_req && stat_pend_q)
            gnt_d = (last_gnt_q == GNT_IMAGE) ? GNT_STATUS : GNT_IMAGE;
          else
            gnt_d = stat_pend_q ? GNT_STATUS : GNT_IMAGE;
          last_gnt_d = gnt_d;
          last_pix_d = 1'b0;
          tx_start   = 1'b1;
          tx_data    = SYNC_BYTE;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_data  = type_byte(gnt_q);
          csum_d   = type_byte(gnt_q);
          state_d  = ST_TYPE;
        end
      end
      ST_TYPE, ST_PAYLOAD: begin
        if (tx_done) begin
          if ((state_q == ST_PAYLOAD) && pl_last) begin
            tx_start = 1'b1;
            tx_data  = csum_q;
            state_d  = ST_CSUM;
          end else begin
            tx_start = 1'b1;
            tx_data  = nxt_byte;
            csum_d   = csum_q + nxt_byte;
            bidx_d   = nxt_idx;
            lo_d     = nxt_lo;
            state_d  = ST_PAYLOAD;
            // Advance the RAM address as the low byte starts, so the next
            // pixel is settled long before its high byte is needed.
            if (gnt_q == GNT_IMAGE) begin
              if (!nxt_lo)                pix_d      = pixel[7:0];
              else if (addr_q == LAST_PIX) last_pix_d = 1'b1;
              else                         addr_d     = addr_q + 17'd1;
            end
          end
        end
      end
      ST_CSUM: begin
        if (tx_done) begin
          state_d = ST_GAP;
          gap_d   = '0;
          addr_d  = '0;
          if (gnt_q == GNT_STATUS) stat_pend_d = 1'b0;
          else                     img_done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IMAGE;
      last_gnt_q  <= GNT_IMAGE;
      stat_pend_q <= 1'b0;
      stat_word_q <= 32'h0;
      csum_q      <= 8'h00;
      addr_q      <= 17'd0;
      lo_q        <= 1'b0;
      bidx_q      <= 2'd0;
      last_pix_q  <= 1'b0;
      pix_q       <= 8'h00;
      gap_q       <= '0;
      img_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      stat_pend_q <= stat_pend_d;
      stat_word_q <= stat_word_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      lo_q        <= lo_d;
      bidx_q      <= bidx_d;
      last_pix_q  <= last_pix_d;
      pix_q       <= pix_d;
      gap_q       <= gap_d;
      img_done_q  <= img_done_d;
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_data),
    .done  (tx_done),
    .tx    (uart_out)
  );

  assign address      = addr_q;
  assign img_done     = img_done_q;
  assign busy         = (state_q != ST_IDLE);
  assign status_ready = !stat_pend_q;

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Directed bench for uart_link_scheduler: decodes the serial line and checks
// packets, timing, arbitration order and reset behaviour.
module tb_uart_link_scheduler;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        img_req = 1'b0;
  logic        img_done;
  logic [16:0] address;
  logic [11:0] pixel = 12'h000;
  logic        status_valid = 1'b0;
  logic [31:0] status_word = 32'h0;
  logic        status_ready;
  logic        uart_out;
  logic        busy;

  logic [11:0] mem [0:3] = '{12'hABC, 12'h001, 12'hFFF, 12'h123};

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         busy_len_q[$];
  int         bit_bad = 0;
  int         idle_run = 0;
  int         busy_run = 0;
  int         done_cnt = 0;
  int         addr_max = 0;
  int         d0;

  always #5 clk = ~clk;

  uart_link_scheduler #(.NUM_PIXELS(4), .CLKS_PER_BIT(CPB), .GAP_CYCLES(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .img_req      (img_req),
    .img_done     (img_done),
    .address      (address),
    .pixel        (pixel),
    .status_valid (status_valid),
    .status_word  (status_word),
    .status_ready (status_ready),
    .uart_out     (uart_out),
    .busy         (busy)
  );

  // Synchronous frame-buffer model: one cycle read latency.
  always @(posedge clk) pixel <= (address < 17'd4) ? mem[address[1:0]] : 12'h000;

  // Line decoder: every bit must hold for exactly CPB samples.
  initial forever begin : rx_mon
    logic [7:0] d;
    int bad;
    bit ab;
    @(negedge clk);
    if (rst) idle_run = 0;
    else if (uart_out) idle_run++;
    else begin
      bad = 0; ab = 1'b0; d = 8'h00;
      for (int i = 1; i < CPB; i++) begin
        @(negedge clk); ab |= rst; if (uart_out !== 1'b0) bad++;
      end
      for (int b = 0; b < 8; b++) begin
        @(negedge clk); ab |= rst; d[b] = uart_out;
        for (int i = 1; i < CPB; i++) begin
          @(negedge clk); ab |= rst; if (uart_out !== d[b]) bad++;
        end
      end
      for (int i = 0; i < CPB; i++) begin
        @(negedge clk); ab |= rst; if (uart_out !== 1'b1) bad++;
      end
      if (!ab) begin
        rx_q.push_back(d);
        gap_q.push_back(idle_run);
        bit_bad += bad;
      end
      idle_run = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (img_done) done_cnt++;
    if (int'(address) > addr_max) addr_max = int'(address);
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len_q.push_back(busy_run);
      busy_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input int base, input int n, input logic [87:0] e);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i),
          (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hFFFF_FFFF,
          {24'h0, e[8*(n-1-i) +: 8]});
  endtask

  task automatic chk_gaps(input string tag, input int base, input int n);
    int nz = 0;
    for (int i = 1; i < n; i++)
      if (base + i < gap_q.size() && gap_q[base + i] != 0) nz++;
    chk(tag, nz, 0);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 4000 && rx_q.size() < n; i++) @(negedge clk);
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 4000 && done_cnt < n; i++) @(negedge clk);
    chk("done_wait", done_cnt, n);
  endtask

  task automatic wait_busy_low();
    for (int i = 0; i < 2000 && busy !== 1'b0; i++) @(negedge clk);
    chk("busy_low", busy, 0);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    gap_q.delete();
    busy_len_q.delete();
    addr_max = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart", uart_out, 1);
    chk("rst_addr", address, 0);
    chk("rst_done", img_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", status_ready, 1);
    rst = 1'b0;

    // Status packet and grant latency
    clear_mon();
    @(posedge clk); #1 status_word = 32'h1234_5678; status_valid = 1'b1;
    @(posedge clk); #1 status_valid = 1'b0; status_word = 32'h0;
    chk("cap_ready", status_ready, 0);
    chk("cap_busy", busy, 0);
    chk("cap_line", uart_out, 1);
    @(posedge clk); #1;
    chk("gnt_busy", busy, 1);
    chk("gnt_start", uart_out, 0);
    wait_rx(7);
    @(negedge clk); @(negedge clk);
    chk("gap_busy", busy, 1);
    chk("gap_ready", status_ready, 1);
    wait_busy_low();
    chk_pkt("st_pkt", 0, 7, 88'h0000_A502_1234_5678_16);
    chk_gaps("st_gaps", 0, 7);
    chk("st_busy_len", (busy_len_q.size() > 0) ? busy_len_q[0] : 0, 300);

    // Image packet
    clear_mon();
    d0 = done_cnt;
    @(posedge clk); #1 img_req = 1'b1;
    wait_done(d0 + 1);
    img_req = 1'b0;
    wait_busy_low();
    chk("img_pulse", done_cnt, d0 + 1);
    chk_pkt("img_pkt", 0, 11, 88'hA5_01_0A_BC_00_01_0F_FF_01_23_FA);
    chk_gaps("img_gaps", 0, 11);
    chk("img_addr_max", addr_max, 3);
    chk("img_addr_end", address, 0);
    chk("img_busy_len", (busy_len_q.size() > 0) ? busy_len_q[0] : 0, 460);

    // Ties after reset: status first, then alternating
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    d0 = done_cnt;
    status_word = 32'h0102_0304; status_valid = 1'b1;
    @(posedge clk); #1 img_req = 1'b1;
    wait_rx(19);
    status_valid = 1'b0;
    wait_done(d0 + 2);
    img_req = 1'b0;
    wait_busy_low();
    chk("tie_bytes", rx_q.size(), 36);
    chk_pkt("tie_p0_st", 0, 7, 88'h0000_A502_0102_0304_0C);
    chk_pkt("tie_p1_img", 7, 11, 88'hA5_01_0A_BC_00_01_0F_FF_01_23_FA);
    chk_pkt("tie_p2_st", 18, 7, 88'h0000_A502_0102_0304_0C);
    chk_pkt("tie_p3_img", 25, 11, 88'hA5_01_0A_BC_00_01_0F_FF_01_23_FA);

    // Status offered mid-image
    clear_mon();
    d0 = done_cnt;
    @(posedge clk); #1 img_req = 1'b1;
    wait_rx(4);
    @(posedge clk); #1 status_word = 32'hDEAD_BEEF; status_valid = 1'b1;
    @(posedge clk); #1 status_valid = 1'b0; status_word = 32'h0;
    chk("mid_ready", status_ready, 0);
    chk("mid_busy", busy, 1);
    wait_done(d0 + 1);
    img_req = 1'b0;
    wait_rx(18);
    wait_busy_low();
    chk_pkt("mid_img", 0, 11, 88'hA5_01_0A_BC_00_01_0F_FF_01_23_FA);
    chk_pkt("mid_st", 11, 7, 88'h0000_A502_DEAD_BEEF_3A);
    chk_gaps("mid_gaps_img", 0, 11);
    chk_gaps("mid_gaps_st", 11, 7);
    chk("mid_ready_end", status_ready, 1);

    // Reset in the middle of an image payload byte
    clear_mon();
    d0 = done_cnt;
    @(posedge clk); #1 img_req = 1'b1;
    wait_rx(3);
    repeat (8) @(negedge clk);
    chk("pre_rst_addr", address, 1);
    @(posedge clk); #1 rst = 1'b1; img_req = 1'b0;
    @(posedge clk); #1;
    chk("mrst_line", uart_out, 1);
    chk("mrst_addr", address, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", img_done, 0);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    chk("mrst_no_done", done_cnt, d0);
    clear_mon();
    #1 img_req = 1'b1;
    wait_done(d0 + 1);
    img_req = 1'b0;
    wait_busy_low();
    chk("again_bytes", rx_q.size(), 11);
    chk_pkt("again_img", 0, 11, 88'hA5_01_0A_BC_00_01_0F_FF_01_23_FA);
    chk("again_addr_max", addr_max, 3);

    chk("bit_width", bit_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_link_scheduler.md
# uart_link_scheduler

Owns the single FPGA→Nano UART link and schedules two requesters onto it: full camera frames read from the frame buffer, and 32-bit robot status words. Each transfer is wrapped in a framed, checksummed packet and serialised 8N1, with non-preemptive round-robin arbitration at packet boundaries. Sits between the frame buffer read port / status logic and the `uart_out` pin.

## Interface
- `NUM_PIXELS`, 76800: pixels per image packet (320×240).
- `CLKS_PER_BIT`, 5208: clk cycles per UART bit (50 MHz / 9600).
- `GAP_CYCLES`, 5000: idle-high cycles enforced after every packet.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `img_req` in 1: level; frame ready to send, held until `img_done`.
- `img_done` out 1: one-cycle pulse after the image packet checksum stop bit.
- `address` out 17: frame buffer read address; synchronous RAM, `pixel` valid 1 cycle later.
- `pixel` in 12: RGB444 pixel data.
- `status_valid` in 1: status word offered.
- `status_word` in 32: status payload.
- `status_ready` out 1: `!status_pend`; capture on `status_valid && status_ready`.
- `uart_out` out 1: serial line, idle high.
- `busy` out 1: high from packet grant until end of gap.

## Operation
- Packet: `0xA5`, type (`0x01` image, `0x02` status), payload, checksum = 8-bit sum of type and payload bytes (mod 256, header excluded).
- Image payload: per pixel, `{4'h0,pixel[11:8]}` then `pixel[7:0]`; addresses 0..NUM_PIXELS-1 in order; 2·NUM_PIXELS bytes.
- Status payload: `status_word` MSB byte first, 4 bytes, taken from the register latched at capture.
- Arbitration: in IDLE, if exactly one request pending, grant it; if both pending, grant the one not granted last (`last_grant` resets to image, so status wins the first tie). No preemption.
- FSM: IDLE → HDR → TYPE → PAYLOAD → CSUM → GAP → IDLE. Each byte state loads the byte, waits for the serialiser done, then advances. In PAYLOAD (image), drive `address`, wait one cycle, latch `pixel`, send both bytes, increment address.
- `status_pend` clears when the status packet's CSUM byte completes; `status_ready` rises the same cycle.
- `img_req` deassertion mid-packet is ignored; packet completes. `img_req` still high after `img_done` → new frame eligible at next IDLE.
- Reset mid-packet: all state abandoned, line returns high next cycle, no `img_done`; receiver resyncs on `0xA5`.

## Timing
- Reset values: `uart_out`=1, `address`=0, `img_done`=0, `busy`=0, `status_ready`=1, state IDLE, `status_pend`=0.
- UART: start 0, 8 data LSB first, stop 1; each bit exactly `CLKS_PER_BIT` cycles; byte = 10·`CLKS_PER_BIT`.
- Grant: request seen in IDLE at cycle N → `busy`=1 and start bit at N+1.
- Consecutive bytes within a packet are back-to-back: next start bit the cycle after prior stop bit ends (pixel fetch latency hidden in stop bit).
- Packet duration: (3 + payload)·10·`CLKS_PER_BIT`, then exactly `GAP_CYCLES` high cycles; `busy` falls and IDLE re-arbitrates after the gap.
- Status capture and CSUM completion same cycle: clear wins, capture occurs next cycle (`status_ready` combinational from the register).

## Structure
- Package `uart_link_pkg`: state enum, `SYNC_BYTE=8'hA5`, `TYPE_IMAGE=8'h01`, `TYPE_STATUS=8'h02`, grant enum.
- Sub-module `uart_byte_tx` (parameter `CLKS_PER_BIT`; ports `clk`, `rst`, `start`, `data[7:0]`, `done`, `tx`): 8N1 serialiser. Scheduler holds FSM, arbiter, checksum accumulator, address counter.

## Test plan
- Status only, `status_word`=0x12345678, CLKS_PER_BIT=4 → bytes A5 02 12 34 56 78 16, then GAP_CYCLES high, `status_ready` high again.
- Image, NUM_PIXELS=4, pixels 0xABC,0x001,0xFFF,0x123 → A5 01 0A BC 00 01 0F FF 01 23 FA; addresses 0..3; one `img_done` pulse.
- Both requests in same cycle after reset → status packet first, image second; repeat → order alternates.
- Status offered mid-image → `status_ready` drops on capture, status packet starts right after image gap; image not corrupted.
- `rst` during image payload byte → `uart_out`=1, `address`=0, `busy`=0 next cycle, no `img_done`; fresh request sends full packet from address 0.
- Bit timing: measure every bit width = `CLKS_PER_BIT`, no idle between bytes inside a packet.
